// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned MEM_BYTES_DEF = 4096;
   localparam int unsigned AW            = 32;
   localparam int unsigned DW            = 32;
   localparam int unsigned BW            = 4;

   localparam logic [BW-1:0] BE_B  = 4'b0001;
   localparam logic [BW-1:0] BE_H  = 4'b0011;
   localparam logic [BW-1:0] BE_HU = 4'b1100;
   localparam logic [BW-1:0] BE_W  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } req_t;

   // Index of the highest enabled byte lane (0 when no lane is enabled).
   function automatic logic [1:0] top_lane(input logic [BW-1:0] be);
      if (be[3])      top_lane = 2'd3;
      else if (be[2]) top_lane = 2'd2;
      else if (be[1]) top_lane = 2'd1;
      else            top_lane = 2'd0;
   endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of one access: empty/misaligned enables or
// bytes past the end of the memory.
module dmem_access_check
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic [AW-1:0] addr,
   input  logic [BW-1:0] be,
   output logic          err_c
);

   logic [AW:0] last_byte;

   always_comb begin
      // One extra bit so an address near 2^32 cannot wrap back into range.
      last_byte = {1'b0, addr} + (AW+1)'(top_lane(be));
      err_c = (be == 4'b0000)
           || (last_byte >= (AW+1)'(MEM_BYTES))
           || ((be == BE_W) && (addr[1:0] != 2'b00))
           || (((be == BE_H) || (be == BE_HU)) && addr[0]);
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: one access in
// flight, IDLE -> ACCESS -> RESP. Define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [31:0]   p0_addr,
   input  logic [31:0]   p0_wdata,
   input  logic [3:0]    p0_be,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [31:0]   p0_rdata,
   output logic          p0_err,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [31:0]   p1_addr,
   input  logic [31:0]   p1_wdata,
   input  logic [3:0]    p1_be,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [31:0]   p1_rdata,
   output logic          p1_err,
   output logic          mem_read,
   output logic          mem_write,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [31:0]   mem_rdata
);

   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [1:0]    rvalid_q, rvalid_d;
   logic [1:0]    rerr_q, rerr_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [BW-1:0] mem_be_q, mem_be_d;
`ifdef DMEM_ARB_RR_EN
   logic          last_q, last_d;
`endif

   logic          win1;
   logic          accept;
   logic          chk_err;
   req_t          sel_req;

   // Arbitration and grant; grant is a same-cycle handshake, masked in reset.
   always_comb begin
      win1 = p1_req && !p0_req;
`ifdef DMEM_ARB_RR_EN
      if (p0_req && p1_req) win1 = !last_q;
`endif
      accept  = rst_n && (state_q == IDLE) && (p0_req || p1_req);
      p0_gnt  = accept && !win1;
      p1_gnt  = accept && win1;
      sel_req = win1 ? {p1_we, p1_addr, p1_wdata, p1_be}
                     : {p0_we, p0_addr, p0_wdata, p0_be};
   end

   dmem_access_check #(
      .MEM_BYTES (MEM_BYTES)
   ) u_check (
      .addr  (sel_req.addr),
      .be    (sel_req.be),
      .err_c (chk_err)
   );

   // Next-state and registered outputs.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      we_d        = we_q;
      err_d       = err_q;
      rvalid_d    = 2'b00;
      rerr_d      = 2'b00;
      rdata0_d    = '0;
      rdata1_d    = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
`ifdef DMEM_ARB_RR_EN
      last_d      = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = ACCESS;
               sel_d       = win1;
               we_d        = sel_req.we;
               err_d       = chk_err;
               mem_addr_d  = sel_req.addr;
               mem_wdata_d = sel_req.wdata;
               mem_be_d    = sel_req.be;
               mem_read_d  = !sel_req.we && !chk_err;
               mem_write_d = sel_req.we && !chk_err;
`ifdef DMEM_ARB_RR_EN
               last_d      = win1;
`endif
            end
         end
         ACCESS: begin
            state_d          = RESP;
            rvalid_d[sel_q]  = 1'b1;
            rerr_d[sel_q]    = err_q;
            if (!we_q && !err_q) begin
               if (sel_q) rdata1_d = mem_rdata;
               else       rdata0_d = mem_rdata;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         rvalid_q    <= 2'b00;
         rerr_q      <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
`ifdef DMEM_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         err_q       <= err_d;
         rvalid_q    <= rvalid_d;
         rerr_q      <= rerr_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
`ifdef DMEM_ARB_RR_EN
         last_q      <= last_d;
`endif
      end
   end

   assign p0_rvalid = rvalid_q[0];
   assign p1_rvalid = rvalid_q[1];
   assign p0_err    = rerr_q[0];
   assign p1_err    = rerr_q[1];
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 4096, byte size of the attached data memory; byte addresses at or above MEM_BYTES are out of range.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pN_req  input  1  requester N (N=0 core LSU, N=1 DMA/debug) access request; held until pN_gnt.
REQ-005 pN_we  input  1  1=store, 0=load; sampled with pN_req.
REQ-006 pN_addr  input  32  byte address.
REQ-007 pN_wdata  input  32  store data, already lane-aligned.
REQ-008 pN_be  input  4  byte enables; 4'b0000 is illegal.
REQ-009 pN_gnt  output  1  one-cycle pulse: request accepted, inputs captured.
REQ-010 pN_rvalid  output  1  one-cycle pulse: access complete (load or store).
REQ-011 pN_rdata  output  32  load data, valid with pN_rvalid; 0 for stores and errors.
REQ-012 pN_err  output  1  valid with pN_rvalid: access rejected, memory untouched.
REQ-013 mem_read, mem_write  output  1 each  memory read and write strobes.
REQ-014 mem_addr, mem_wdata  output  32 each; mem_be  output  4  memory command.
REQ-015 mem_rdata  input  32  combinational read data from memory.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS on any accepted request.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-017 Acceptance:
- Only in IDLE; exactly one pN_gnt pulses in the accept cycle.
- Requester id, we, addr, wdata and be are registered on that edge.
REQ-018 Arbitration, both requesting in the same IDLE cycle: fixed priority, port 0 wins (see REQ-028).
REQ-019 ACCESS cycle (registered outputs):
- mem_addr, mem_wdata and mem_be come from the captured values.
- Exactly one of mem_read and mem_write is 1, unless an error is flagged.
REQ-020 Loads: mem_rdata is captured at the end of ACCESS and presented on pN_rdata during RESP.
REQ-021 Stores: commit at the posedge ending ACCESS.
REQ-022 Latency: gnt edge to rvalid is 2 cycles. Peak throughput is one access per 3 cycles.
REQ-023 Error is flagged at capture if any of the following hold:
- be == 0;
- addr + highest enabled lane >= MEM_BYTES;
- be == 4'b1111 with addr[1:0] != 0;
- be in {0011, 1100} with addr[0] != 0.
REQ-024 On an error:
- ACCESS drives both strobes 0.
- RESP pulses pN_rvalid with pN_err=1 and pN_rdata=0.
REQ-025 Outside ACCESS: mem_read = mem_write = 0, and mem_addr, mem_wdata, mem_be hold their last values.
REQ-026 Requester boundary conditions:
- pN_req dropping before gnt cancels that request with no side effects.
- pN_req asserted during ACCESS or RESP waits; it is never lost while held.
- The granted requester's new inputs are ignored until RESP completes.
- The non-granted port's pN_rvalid, pN_err and pN_rdata stay 0.

Reset
REQ-027 Asynchronous assertion of rst_n:
- State goes to IDLE.
- All gnt, rvalid, err and mem strobes go to 0.
- rdata, mem_addr, mem_wdata and mem_be go to 0.
- The round-robin pointer selects port 0.
- A reset asserted during ACCESS suppresses the pending write, because mem_write is already 0 at the edge.

Configuration
REQ-028 DMEM_ARB_RR_EN:
- Defined: round-robin arbitration. A last-granted pointer flips on each grant, and on contention the port not last granted wins.
- Undefined: fixed priority, port 0 always wins, and no pointer register exists.

Structure
REQ-029 Shared package dmem_pkg holds:
- state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
- MEM_BYTES default;
- byte-enable constants BE_B=4'b0001, BE_H=4'b0011, BE_W=4'b1111.
REQ-030 One sub-module, dmem_access_check: combinational error detection (REQ-023) from addr, be and MEM_BYTES.

Verification
REQ-031 Bench pairs dmem_arbiter with data_memory, 10 ns clock, and covers these scenarios:
- p0 store addr=0x0 wdata=0xDEADBEEF be=1111, then p0 load addr=0x0 -> p0_rvalid 2 cycles after gnt, p0_rdata=0xDEADBEEF, p0_err=0.
- p0 and p1 both request a load in the same cycle -> p0_gnt first, p1_gnt in the next IDLE. With DMEM_ARB_RR_EN and a second simultaneous pair, p1 wins instead.
- p1 store addr=0x6 be=1100 wdata=0xBEEF0000 -> mem_write pulses 1 cycle; p0 load addr=0x4 returns 0xBEEF0000.
- p0 load addr=0x2 be=1111 -> p0_err=1, p0_rdata=0, mem_read never asserted. p0 store addr=0xFFE be=1111 -> p0_err=1.
- Reset: rst_n low during ACCESS of p0 store addr=0x10 wdata=0x12345678 -> outputs zero immediately; later load addr=0x10 returns 0x00000000.
- p1_req pulsed one cycle while p0 is in ACCESS, then dropped -> p1_gnt never asserts, memory unchanged.
